// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// oversampling constants. The state encoding is shared with the transmitter.
package uart_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } rx_state_e;

  // s_tick pulses per bit period
  localparam int OVERSAMPLE = 16;
  // tick index at the middle of the start bit
  localparam int MID_TICK   = 7;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side bundle: serial line and oversample enable in, received
// byte, done strobe and framing error out.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);

  logic                 s_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] dout;
  logic                 rx_done_tick;
  logic                 frame_err;

  // Drives the line and tick, consumes the received byte.
  modport master (
    output s_tick, rx,
    input  dout, rx_done_tick, frame_err
  );

  // The receiver itself.
  modport slave (
    input  s_tick, rx,
    output dout, rx_done_tick, frame_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pad. Resets to 1 (line idle)
// so that reset never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the pad value through two flops into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample their old
      // inputs on the same edge; blocking here would collapse the chain.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled 8N1 UART receiver. Start bit is qualified at its middle,
// data bits are sampled mid-bit LSB first, and the stop bit decides
// frame_err. An armed flag keeps a held-low (break) line from re-triggering.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  uart_receiver_if.slave  bus
);

  // Tick counter must reach STOP_BITS_TICK-1 for 1.5/2 stop bits.
  localparam int S_W = (STOP_BITS_TICK > OVERSAMPLE) ? $clog2(STOP_BITS_TICK)
                                                     : $clog2(OVERSAMPLE);
  localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [S_W-1:0] S_MID  = S_W'(MID_TICK);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(STOP_BITS_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

  rx_state_e            state;
  logic [S_W-1:0]       s;
  logic [N_W-1:0]       n;
  logic [DATA_BITS-1:0] b;
  logic                 armed;
  logic                 rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  // Receive FSM with tick/bit counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      s                <= '0;
      n                <= '0;
      b                <= '0;
      armed            <= 1'b0;
      bus.dout         <= '0;
      bus.rx_done_tick <= 1'b0;
      bus.frame_err    <= 1'b0;
    end else begin
      bus.rx_done_tick <= 1'b0;
      case (state)
        // Start detection runs every clk, independent of s_tick.
        ST_IDLE: begin
          if (armed && !rx_s) begin
            state <= ST_START;
            s     <= '0;
            armed <= 1'b0;
          end else if (rx_s) begin
            armed <= 1'b1;
          end
        end

        ST_START: begin
          if (bus.s_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= ST_DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                // Line went high before mid start bit: glitch, drop it.
                state <= ST_IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (bus.s_tick) begin
            if (s == S_LAST) begin
              b <= {rx_s, b[DATA_BITS-1:1]};
              s <= '0;
              if (n == N_LAST) state <= ST_STOP;
              else             n     <= n + 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (bus.s_tick) begin
            if (s == S_STOP) begin
              state            <= ST_IDLE;
              // A high stop bit proves the line is idle, so a start edge
              // right after the stop sample is accepted without a re-arm gap.
              armed            <= rx_s;
              bus.dout         <= b;
              bus.frame_err    <= ~rx_s;
              bus.rx_done_tick <= 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: a behavioural transmitter drives rx
// on a shared s_tick, expected bytes go into a scoreboard when a frame is
// sent, and a monitor compares every rx_done_tick against the queue head.
module tb_uart_receiver;

  typedef struct {
    logic [7:0] dout;
    logic       err;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_dout;
    logic       exp_err;
  } vec_t;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;
  int   tick_div = 3;
  logic prev_done = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  uart_receiver_if #(.DATA_BITS(8)) bus ();

  uart_receiver #(
    .DATA_BITS      (8),
    .STOP_BITS_TICK (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One s_tick period; s_tick is high for the last clk of the period.
  task automatic do_tick();
    for (int i = 0; i < tick_div - 1; i++) begin
      @(negedge clk);
      bus.s_tick = 1'b0;
    end
    @(negedge clk);
    bus.s_tick = 1'b1;
  endtask

  task automatic send_bit(input logic v);
    bus.rx = v;
    repeat (16) do_tick();
  endtask

  task automatic idle_ticks(input int k);
    bus.rx = 1'b1;
    repeat (k) do_tick();
  endtask

  // Full 8N1 frame; the expected result is queued as the frame starts.
  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input logic [7:0] exp_d, input logic exp_err);
    exp_t e;
    e.dout = exp_d;
    e.err  = exp_err;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_v);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the DUT update.
  always @(negedge clk) begin
    if (!reset && bus.rx_done_tick) begin
      pulses++;
      check("done_width", {31'b0, prev_done}, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("dout", {24'b0, bus.dout}, {24'b0, mon_e.dout});
        check("frame_err", {31'b0, bus.frame_err}, {31'b0, mon_e.err});
      end
    end
    prev_done = bus.rx_done_tick;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    int   p0;
    logic [7:0] rb;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_dout: 8'hA5, exp_err: 1'b0};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_dout: 8'h3C, exp_err: 1'b1};
    vecs[2] = '{data: 8'h5E, stop: 1'b1, exp_dout: 8'h5E, exp_err: 1'b0};
    vecs[3] = '{data: 8'hC3, stop: 1'b0, exp_dout: 8'hC3, exp_err: 1'b1};

    reset      = 1'b1;
    bus.rx     = 1'b1;
    bus.s_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", {24'b0, bus.dout}, 0);
    check("reset_done", {31'b0, bus.rx_done_tick}, 0);
    check("reset_err",  {31'b0, bus.frame_err}, 0);
    reset = 1'b0;
    idle_ticks(8);

    // Table-driven frames, idle gap before each so a low stop re-arms.
    for (int i = 0; i < 4; i++) begin
      idle_ticks(16);
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].exp_dout, vecs[i].exp_err);
      wait_drain("vec_drain");
    end

    // Glitch: low for 4 ticks then high; no pulse, dout holds.
    idle_ticks(16);
    p0 = pulses;
    bus.rx = 1'b0;
    repeat (4) do_tick();
    idle_ticks(32);
    check("glitch_no_done", pulses - p0, 0);
    check("glitch_dout_hold", {24'b0, bus.dout}, 32'hC3);

    // Framing error then line held low (break) for 40 bit times.
    send_frame(8'h3C, 1'b0, 8'h3C, 1'b1);
    wait_drain("break_frame_drain");
    p0 = pulses;
    bus.rx = 1'b0;
    repeat (40 * 16) do_tick();
    check("break_no_done", pulses - p0, 0);
    idle_ticks(16);
    send_frame(8'h11, 1'b1, 8'h11, 1'b0);
    wait_drain("after_break_drain");
    check("after_break_pulses", pulses - p0, 1);

    // Back-to-back frames, no idle gap.
    idle_ticks(16);
    p0 = pulses;
    send_frame(8'h00, 1'b1, 8'h00, 1'b0);
    send_frame(8'hFF, 1'b1, 8'hFF, 1'b0);
    send_frame(8'h81, 1'b1, 8'h81, 1'b0);
    wait_drain("b2b_drain");
    check("b2b_pulses", pulses - p0, 3);

    // Reset after the third data bit of 0x77, then a clean 0x5A.
    idle_ticks(16);
    p0 = pulses;
    rb = 8'h77;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(rb[i]);
    @(negedge clk);
    reset      = 1'b1;
    bus.s_tick = 1'b0;
    bus.rx     = 1'b1;
    @(negedge clk);
    check("midreset_dout", {24'b0, bus.dout}, 0);
    check("midreset_done", {31'b0, bus.rx_done_tick}, 0);
    check("midreset_err",  {31'b0, bus.frame_err}, 0);
    reset = 1'b0;
    idle_ticks(32);
    send_frame(8'h5A, 1'b1, 8'h5A, 1'b0);
    wait_drain("midreset_drain");
    check("midreset_pulses", pulses - p0, 1);

    // Loopback: 256 random bytes back-to-back at one tick per clk.
    tick_div = 1;
    idle_ticks(16);
    p0 = pulses;
    for (int i = 0; i < 256; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, rb, 1'b0);
    end
    wait_drain("loop_drain");
    check("loop_pulses", pulses - p0, 256);
    idle_ticks(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
